// File: rtl/serial_rx_param_if.sv
// serial_rx_param_if: serial line in, received word and status strobes out.
// master drives the line; slave is the receiver.
interface serial_rx_param_if #(
  parameter int DATA_W = 8
);
  logic              in;
  logic [DATA_W-1:0] out_byte;
  logic              done;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  modport master (
    output in,
    input  out_byte, done, parity_err, frame_err, busy
  );

  modport slave (
    input  in,
    output out_byte, done, parity_err, frame_err, busy
  );
endinterface

// File: rtl/serial_rx_param.sv
// serial_rx_param: idle-high serial frame receiver, LSB first, 1..2 stop bits.
// Parity bit and PARITY state exist only when SERIAL_RX_PARITY_EN is defined.
module serial_rx_param #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b1,
  parameter int STOP_BITS  = 1
) (
  input logic              clk,
  input logic              reset,
  serial_rx_param_if.slave bus
);
  localparam int CW = $clog2(DATA_W + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DATA    = 3'd1;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;
`ifdef SERIAL_RX_PARITY_EN
  localparam logic [2:0] S_PARITY  = 3'd2;
`endif

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              stop_q, stop_d;
  logic              done_q, done_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              bad;
  logic              last_stop;
`ifdef SERIAL_RX_PARITY_EN
  logic              par_q, par_d;
  logic              bad_q, bad_d;
  assign bad = bad_q;
`else
  assign bad = 1'b0 & PARITY_ODD;
`endif

  assign last_stop = (stop_q == 1'(STOP_BITS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    out_d   = out_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_d   = par_q;
    bad_d   = bad_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!bus.in) begin
          state_d = S_DATA;
          cnt_d   = '0;
          stop_d  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      S_DATA: begin
        // Right shift: after DATA_W bits the first bit lands in bit 0.
        shift_d = (shift_q >> 1) | (DATA_W'(bus.in) << (DATA_W - 1));
        cnt_d   = cnt_q + 1'b1;
`ifdef SERIAL_RX_PARITY_EN
        par_d   = par_q ^ bus.in;
        if (cnt_q == CW'(DATA_W - 1)) state_d = S_PARITY;
`else
        if (cnt_q == CW'(DATA_W - 1)) state_d = S_STOP;
`endif
      end
`ifdef SERIAL_RX_PARITY_EN
      S_PARITY: begin
        bad_d   = ((par_q ^ bus.in) != PARITY_ODD);
        state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (!bus.in) begin
          state_d = S_RECOVER;
          ferr_d  = 1'b1;
        end else if (last_stop) begin
          state_d = S_IDLE;
          if (bad) begin
            perr_d = 1'b1;
          end else begin
            done_d = 1'b1;
            out_d  = shift_q;
          end
        end else begin
          stop_d = 1'b1;
        end
      end
      S_RECOVER: begin
        if (bus.in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      out_q   <= '0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_q   <= 1'b0;
      bad_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
`ifdef SERIAL_RX_PARITY_EN
      par_q   <= par_d;
      bad_q   <= bad_d;
`endif
    end
  end

  assign bus.out_byte   = out_q;
  assign bus.done       = done_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_serial_rx_param.sv
// tb_serial_rx_param: directed frames into two receiver configurations;
// expected strobes are queued by the driver and checked by monitors.
module tb_serial_rx_param;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef SERIAL_RX_PARITY_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  localparam logic [2:0] K_DONE = 3'b100;
  localparam logic [2:0] K_PERR = 3'b010;
  localparam logic [2:0] K_FERR = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  serial_rx_param_if #(.DATA_W(8))  ifa ();
  serial_rx_param_if #(.DATA_W(12)) ifb ();

  serial_rx_param #(
    .DATA_W(8), .PARITY_ODD(1'b1), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );

  serial_rx_param #(
    .DATA_W(12), .PARITY_ODD(1'b0), .STOP_BITS(2)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit sel, input logic b);
    @(negedge clk);
    if (sel) ifb.in = b;
    else ifa.in = b;
  endtask

  // Send one frame; queue the strobe kind and out_byte expected after it.
  task automatic send(input bit sel, input logic [15:0] d, input bit pflip,
                      input bit bad0, input bit bad1,
                      input logic [2:0] kind, input logic [15:0] exp_out);
    int   w;
    int   ns;
    bit   podd;
    bit   x;
    bit   b;
    exp_t e;
    w    = sel ? 12 : 8;
    ns   = sel ? 2 : 1;
    podd = sel ? 1'b0 : 1'b1;
    x    = 1'b0;
    drive(sel, 1'b0);
    for (int i = 0; i < w; i++) begin
      drive(sel, d[i]);
      x = x ^ d[i];
    end
    if (PE) drive(sel, (podd ? ~x : x) ^ pflip);
    for (int s = 0; s < ns; s++) begin
      b = (s == 0) ? ~bad0 : ~bad1;
      drive(sel, b);
      if (!b) break;
    end
    e.kind = kind;
    e.data = exp_out;
    e.cyc  = cyc + 1;
    if (sel) qb.push_back(e);
    else qa.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (ifa.done | ifa.parity_err | ifa.frame_err) begin
        if (qa.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL a_unexpected_strobe actual=%b required=000",
                   {ifa.done, ifa.parity_err, ifa.frame_err});
        end else begin
          e = qa.pop_front();
          cmp("a_kind", 32'({ifa.done, ifa.parity_err, ifa.frame_err}), 32'(e.kind));
          cmp("a_out_byte", 32'(ifa.out_byte), 32'(e.data));
          cmp("a_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (ifb.done | ifb.parity_err | ifb.frame_err) begin
        if (qb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL b_unexpected_strobe actual=%b required=000",
                   {ifb.done, ifb.parity_err, ifb.frame_err});
        end else begin
          e = qb.pop_front();
          cmp("b_kind", 32'({ifb.done, ifb.parity_err, ifb.frame_err}), 32'(e.kind));
          cmp("b_out_byte", 32'(ifb.out_byte), 32'(e.data));
          cmp("b_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    reset  = 1'b1;
    ifa.in = 1'b1;
    ifb.in = 1'b1;
    repeat (2) @(negedge clk);
    cmp("rst_out_byte", 32'(ifa.out_byte), 32'h0);
    cmp("rst_strobes", 32'({ifa.done, ifa.parity_err, ifa.frame_err}), 32'h0);
    cmp("rst_busy", 32'(ifa.busy), 32'h0);
    cmp("rst_b_out_byte", 32'(ifb.out_byte), 32'h0);
    reset = 1'b0;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);

    send(1'b0, 16'h00A5, 1'b0, 1'b0, 1'b0, K_DONE, 16'h00A5);
    send(1'b0, 16'h0096, 1'b1, 1'b0, 1'b0,
         PE ? K_PERR : K_DONE, PE ? 16'h00A5 : 16'h0096);
    drive(1'b0, 1'b1);

    send(1'b0, 16'h0077, 1'b0, 1'b1, 1'b0,
         K_FERR, PE ? 16'h00A5 : 16'h0096);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0);
      cmp("recover_busy", 32'(ifa.busy), 32'h1);
    end
    drive(1'b0, 1'b1);
    cmp("recover_busy_exit", 32'(ifa.busy), 32'h1);
    drive(1'b0, 1'b1);
    cmp("idle_after_recover", 32'(ifa.busy), 32'h0);
    send(1'b0, 16'h003C, 1'b0, 1'b0, 1'b0, K_DONE, 16'h003C);

    send(1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, K_DONE, 16'h0001);
    send(1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0, K_DONE, 16'h00FF);
    drive(1'b0, 1'b1);

    send(1'b1, 16'h0ABC, 1'b0, 1'b0, 1'b1, K_FERR, 16'h0000);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    send(1'b1, 16'h0ABC, 1'b0, 1'b0, 1'b0, K_DONE, 16'h0ABC);
    drive(1'b1, 1'b1);

    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    cmp("async_rst_out_byte", 32'(ifa.out_byte), 32'h0);
    cmp("async_rst_busy", 32'(ifa.busy), 32'h0);
    cmp("async_rst_strobes", 32'({ifa.done, ifa.parity_err, ifa.frame_err}), 32'h0);
    @(negedge clk);
    reset  = 1'b0;
    ifa.in = 1'b1;
    drive(1'b0, 1'b1);
    send(1'b0, 16'h005A, 1'b0, 1'b0, 1'b0, K_DONE, 16'h005A);
    drive(1'b0, 1'b1);

    for (int i = 0; i < 40 && (qa.size() != 0 || qb.size() != 0); i++)
      @(negedge clk);
    repeat (4) @(negedge clk);
    cmp("a_pending", qa.size(), 32'h0);
    cmp("b_pending", qb.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
